// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the transmitter state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: o_tick marks the last cycle of a DIV-cycle bit, o_pre_tick the cycle before it.
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick     = (cnt_q == LAST);
    assign o_pre_tick = (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: START, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Handshake: a payload is taken on any rising edge with i_valid=1 and o_ready=1; o_ready is high only in IDLE.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic [2:0]           o_state
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic HAS_PAR = (PARITY != PARITY_NONE);
    localparam logic ODD_PAR = (PARITY == PARITY_ODD);

    if (DIV < 2) begin : g_chk_div
        $error("uart_tx_framed: CLK_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 tick, pre_tick, last_stop;

    // The timer is held at zero in IDLE, so the acceptance edge starts the START bit from count 0.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_restart  (state_q == ST_IDLE),
        .o_tick     (tick),
        .o_pre_tick (pre_tick)
    );

    assign last_stop = (STOP_BITS == 1) || stop_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (i_valid) begin
                    state_d = ST_START;
                    shift_d = i_data;
                    par_d   = (^i_data) ^ ODD_PAR;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        tx_d    = HAS_PAR ? par_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                // Leave one cycle early: the IDLE cycle that follows still drives the
                // line high and finishes the last stop bit, so a held i_valid starts
                // the next frame with no extra idle time.
                tx_d = 1'b1;
                if (last_stop) begin
                    if (pre_tick) begin
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = tx_q;
    assign o_state = state_q;

endmodule
